rf80386_icache: RTL and testbench

- Instruction-fetch cache directly upstream of the rf80386 core.
- Takes the core's linear fetch address csip and returns a byte-aligned 128-bit instruction window, ibundle, plus ihit.
- On a miss it fills 16-byte lines over the fta 128-bit bus.
- Two interleaved direct-mapped banks (even and odd line index) let any unaligned 16-byte window, which spans at most two lines, hit in a single cycle.

---
 rtl/rf80386_pkg.sv | 56 +++++
 rtl/rf80386_icache_bank.sv | 51 +++++
 rtl/rf80386_icache.sv | 179 +++++++++++++++++
 tb/tb_rf80386_icache.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf80386_pkg.sv
// Shared types for the rf80386 core slice: fta bus command structs and
// instruction-cache state/line types.
package rf80386_pkg;

    localparam int unsigned ICACHE_LINE_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RTYW
    } icache_state_t;

    typedef struct packed {
        logic [27:0]  tag;
        logic [127:0] data;
    } icache_line_t;

    typedef enum logic [4:0] {
        CMD_NONE  = 5'd0,
        CMD_LOAD  = 5'd1,
        CMD_STORE = 5'd2
    } fta_cmd_t;

    typedef struct packed {
        logic [5:0] core;
        logic [2:0] channel;
        logic [3:0] tranid;
    } fta_tranid_t;

    typedef struct packed {
        fta_tranid_t  tid;
        fta_cmd_t     cmd;
        logic         cyc;
        logic         stb;
        logic         we;
        logic [15:0]  sel;
        logic [31:0]  adr;
        logic [127:0] dat;
    } fta_cmd_request128_t;

    typedef struct packed {
        fta_tranid_t  tid;
        logic         ack;
        logic         rty;
        logic         err;
        logic [31:0]  adr;
        logic [127:0] dat;
    } fta_cmd_response128_t;

    // Transaction ids run 1..15; 0 is reserved so a cleared pending id never matches.
    function automatic logic [3:0] next_tid(input logic [3:0] t);
        return (t == 4'd15) ? 4'd1 : t + 4'd1;
    endfunction

endpackage

// File: rtl/rf80386_icache_bank.sv
// One direct-mapped bank of the instruction cache: LUT RAM for tag and data
// with asynchronous read, synchronous write, and a clearable valid vector.
module rf80386_icache_bank
    import rf80386_pkg::*;
#(
    parameter int unsigned NLINES = 128,
    parameter int unsigned LW     = 7
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              we_i,
    input  logic [LW-1:0]     widx_i,
    input  logic [26-LW:0]    wtag_i,
    input  logic [127:0]      wdat_i,
    input  logic [LW-1:0]     ridx_i,
    output icache_line_t      rline_o,
    output logic              rvalid_o
);

    localparam int unsigned TAGW = 27 - LW;

    logic [TAGW-1:0]   tag_mem  [NLINES];
    logic [127:0]      data_mem [NLINES];
    logic [NLINES-1:0] valid_q;

    // Tag and data storage: written on a completed fill.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            tag_mem[widx_i]  <= wtag_i;
            data_mem[widx_i] <= wdat_i;
        end
    end

    // Valid bits: reset and invalidate win over a same-cycle fill.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[widx_i] <= 1'b1;
        end
    end

    // Asynchronous read; tag is zero-extended to the full line-number width.
    always_comb begin
        rline_o.tag  = {{(LW+1){1'b0}}, tag_mem[ridx_i]};
        rline_o.data = data_mem[ridx_i];
        rvalid_o     = valid_q[ridx_i];
    end

endmodule

// File: rtl/rf80386_icache.sv
// Instruction-fetch cache: two interleaved banks give a single-cycle hit on
// any unaligned 16-byte window; misses fill one line at a time over fta.
module rf80386_icache
    import rf80386_pkg::*;
#(
    parameter logic [5:0]  CORENO  = 6'd1,
    parameter logic [2:0]  CID     = 3'd2,
    parameter int unsigned NLINES  = 128,
    parameter logic [4:0]  RTY_DLY = 5'd8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          csip,
    output logic [127:0]         ibundle,
    output logic                 ihit,
    input  logic                 inv_i,
    output fta_cmd_request128_t  ftam_req,
    input  fta_cmd_response128_t ftam_resp
);

    localparam int unsigned LW = $clog2(NLINES);

    icache_state_t       state_q;
    fta_cmd_request128_t req_q;
    logic [27:0]         fill_line_q;
    logic [3:0]          tid_q;
    logic [3:0]          pend_tid_q;
    logic                discard_q;
    logic [4:0]          rty_cnt_q;

    logic [27:0]  line_a, line_b, even_line, odd_line, tag_a, tag_b, fill_sel;
    icache_line_t even_rd, odd_rd;
    logic         even_vld, odd_vld, hit_a, hit_b;
    logic [127:0] data_a, data_b;
    logic [255:0] window;
    logic [4:0]   bidx;
    logic         resp_match, fill_we;

    // Lookup: pick which bank holds line L and which holds L+1, then tag-compare both.
    always_comb begin
        line_a    = csip[31:4];
        line_b    = line_a + 28'd1;
        even_line = line_a[0] ? line_b : line_a;
        odd_line  = line_a[0] ? line_a : line_b;
        tag_a     = line_a >> (LW + 1);
        tag_b     = line_b >> (LW + 1);
        hit_a     = line_a[0] ? (odd_vld && odd_rd.tag == tag_a)
                              : (even_vld && even_rd.tag == tag_a);
        hit_b     = line_b[0] ? (odd_vld && odd_rd.tag == tag_b)
                              : (even_vld && even_rd.tag == tag_b);
        data_a    = line_a[0] ? odd_rd.data : even_rd.data;
        data_b    = line_b[0] ? odd_rd.data : even_rd.data;
        ihit      = hit_a && hit_b;
        fill_sel  = hit_a ? line_b : line_a;
    end

    // Alignment shifter: byte i of the window is byte csip[3:0]+i of {lineB,lineA}.
    always_comb begin
        window  = {data_b, data_a};
        ibundle = '0;
        bidx    = '0;
        for (int unsigned i = 0; i < ICACHE_LINE_BYTES; i++) begin
            bidx = {1'b0, csip[3:0]} + 5'(i);
            ibundle[i*8 +: 8] = window[bidx*8 +: 8];
        end
    end

    // Response qualification and fill write (dropped when discarding or invalidating).
    always_comb begin
        resp_match = (ftam_resp.tid.core == CORENO) && (ftam_resp.tid.channel == CID)
                     && (ftam_resp.tid.tranid == pend_tid_q);
        fill_we    = (state_q == WAIT) && resp_match && ftam_resp.ack
                     && !discard_q && !inv_i;
    end

    rf80386_icache_bank #(.NLINES(NLINES), .LW(LW)) u_even (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (inv_i),
        .we_i     (fill_we && !fill_line_q[0]),
        .widx_i   (fill_line_q[LW:1]),
        .wtag_i   (fill_line_q[27:LW+1]),
        .wdat_i   (ftam_resp.dat),
        .ridx_i   (even_line[LW:1]),
        .rline_o  (even_rd),
        .rvalid_o (even_vld)
    );

    rf80386_icache_bank #(.NLINES(NLINES), .LW(LW)) u_odd (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (inv_i),
        .we_i     (fill_we && fill_line_q[0]),
        .widx_i   (fill_line_q[LW:1]),
        .wtag_i   (fill_line_q[27:LW+1]),
        .wdat_i   (ftam_resp.dat),
        .ridx_i   (odd_line[LW:1]),
        .rline_o  (odd_rd),
        .rvalid_o (odd_vld)
    );

    function automatic fta_cmd_request128_t idle_req(input fta_cmd_request128_t r);
        fta_cmd_request128_t o = r;
        o.cyc = 1'b0;
        o.stb = 1'b0;
        o.we  = 1'b0;
        o.cmd = CMD_NONE;
        o.sel = '0;
        return o;
    endfunction

    function automatic fta_cmd_request128_t load_req(input logic [27:0] line,
                                                     input logic [3:0]  tranid);
        fta_cmd_request128_t o = '0;
        o.tid.core    = CORENO;
        o.tid.channel = CID;
        o.tid.tranid  = tranid;
        o.cmd         = CMD_LOAD;
        o.cyc         = 1'b1;
        o.stb         = 1'b1;
        o.sel         = 16'hFFFF;
        o.adr         = {line, 4'h0};
        return o;
    endfunction

    // Fill FSM with registered bus request; bus err is retried like rty.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q             <= IDLE;
            req_q               <= '0;
            req_q.tid.core      <= CORENO;
            req_q.tid.channel   <= CID;
            fill_line_q         <= '0;
            tid_q               <= 4'd1;
            pend_tid_q          <= '0;
            discard_q           <= 1'b0;
            rty_cnt_q           <= '0;
        end else begin
            req_q <= idle_req(req_q);
            case (state_q)
                IDLE: begin
                    discard_q <= 1'b0;
                    if (!ihit && !inv_i) begin
                        fill_line_q <= fill_sel;
                        req_q       <= load_req(fill_sel, tid_q);
                        pend_tid_q  <= tid_q;
                        tid_q       <= next_tid(tid_q);
                        state_q     <= REQ;
                    end
                end
                REQ: state_q <= WAIT;
                WAIT: begin
                    if (inv_i) discard_q <= 1'b1;
                    if (resp_match && ftam_resp.ack) begin
                        state_q <= IDLE;
                    end else if (resp_match && (ftam_resp.rty || ftam_resp.err)) begin
                        rty_cnt_q <= RTY_DLY;
                        state_q   <= RTYW;
                    end
                end
                RTYW: begin
                    if (inv_i) discard_q <= 1'b1;
                    if (rty_cnt_q == '0) begin
                        req_q      <= load_req(fill_line_q, tid_q);
                        pend_tid_q <= tid_q;
                        tid_q      <= next_tid(tid_q);
                        state_q    <= REQ;
                    end else begin
                        rty_cnt_q <= rty_cnt_q - 5'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ftam_req = req_q;

endmodule

// File: tb/tb_rf80386_icache.sv
// Scoreboard bench for rf80386_icache: expected bus requests are queued by the
// stimulus and checked by a monitor; hit/window checks use a byte-address model.
module tb_rf80386_icache;
    import rf80386_pkg::*;

    localparam int unsigned NL  = 128;
    localparam int unsigned RTY = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 inv;
    logic [31:0]          csip;
    logic [127:0]         ibundle;
    logic                 ihit;
    fta_cmd_request128_t  req;
    fta_cmd_response128_t resp;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] adr;
        logic [3:0]  tid;
    } exp_req_t;
    exp_req_t exq[$];

    rf80386_icache #(.CORENO(6'd1), .CID(3'd2), .NLINES(NL), .RTY_DLY(5'd8)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .csip      (csip),
        .ibundle   (ibundle),
        .ihit      (ihit),
        .inv_i     (inv),
        .ftam_req  (req),
        .ftam_resp (resp)
    );

    always #5 clk = ~clk;

    // Memory model: byte value is its address low byte, with bit 7 flipped by address bit 13.
    function automatic logic [7:0] bytefn(input logic [31:0] a);
        return a[7:0] ^ {a[13], 7'b0};
    endfunction

    function automatic logic [127:0] mem_bytes(input logic [31:0] a);
        logic [127:0] d;
        for (int i = 0; i < 16; i++) d[i*8 +: 8] = bytefn(a + 32'(i));
        return d;
    endfunction

    task automatic push(input logic [31:0] a, input logic [3:0] t);
        exp_req_t e;
        e.adr = a;
        e.tid = t;
        exq.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Request monitor: every issued request must match the head of the queue.
    always @(negedge clk) begin
        if (req.cyc === 1'b1) begin
            checks++;
            if (exq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_req: got adr=%h tid=%0d expected none", req.adr, req.tid.tranid);
            end else begin
                exp_req_t e;
                e = exq.pop_front();
                if (req.adr !== e.adr || req.tid.tranid !== e.tid || req.stb !== 1'b1 ||
                    req.we !== 1'b0 || req.cmd !== CMD_LOAD || req.sel !== 16'hFFFF ||
                    req.tid.core !== 6'd1 || req.tid.channel !== 3'd2) begin
                    errors++;
                    $display("FAIL req: got adr=%h tid=%0d cmd=%0d sel=%h we=%b expected adr=%h tid=%0d cmd=LOAD sel=FFFF we=0",
                             req.adr, req.tid.tranid, req.cmd, req.sel, req.we, e.adr, e.tid);
                end
            end
        end
    end

    task automatic wait_req(output logic [3:0] t, output logic [31:0] a);
        int n = 0;
        while (req.cyc !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        if (req.cyc !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: got no request expected one within 100 cycles");
        end
        t = req.tid.tranid;
        a = req.adr;
        step();
    endtask

    task automatic respond(input logic [3:0] t, input logic [31:0] a, input bit is_rty,
                           input logic [2:0] ch);
        resp.tid.core    = 6'd1;
        resp.tid.channel = ch;
        resp.tid.tranid  = t;
        resp.ack         = !is_rty;
        resp.rty         = is_rty;
        resp.err         = 1'b0;
        resp.adr         = a;
        resp.dat         = mem_bytes(a);
        step();
        resp = '0;
    endtask

    task automatic fill();
        logic [3:0]  t;
        logic [31:0] a;
        wait_req(t, a);
        respond(t, a, 1'b0, 3'd2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        fta_cmd_request128_t r0;
        logic [3:0]  t;
        logic [31:0] a;
        int          n;
        rst  = 1'b1;
        inv  = 1'b0;
        csip = 32'hFFFF0000;
        resp = '0;
        repeat (3) step();
        r0 = '0;
        r0.tid.core    = 6'd1;
        r0.tid.channel = 3'd2;
        chk("reset_ihit", 128'(ihit), 128'd0);
        checks++;
        if (req !== r0) begin
            errors++;
            $display("FAIL reset_req: got %h expected %h", req, r0);
        end

        // Cold miss at csip with offset 0: both lines fetched, tids 1 and 2.
        push(32'hFFFF0000, 4'd1);
        push(32'hFFFF0010, 4'd2);
        rst = 1'b0;
        fill();
        chk("one_line_only_ihit", 128'(ihit), 128'd0);
        fill();
        chk("cold_ihit", 128'(ihit), 128'd1);
        chk("cold_byte0", 128'(ibundle[7:0]), 128'(bytefn(32'hFFFF0000)));
        chk("cold_bundle", ibundle, mem_bytes(32'hFFFF0000));

        // Unaligned window across two lines.
        push(32'h00001000, 4'd3);
        push(32'h00001010, 4'd4);
        csip = 32'h00001003;
        fill();
        fill();
        chk("unal_ihit", 128'(ihit), 128'd1);
        chk("unal_byte0", 128'(ibundle[7:0]), 128'h03);
        chk("unal_byte15", 128'(ibundle[127:120]), 128'h12);
        chk("unal_bundle", ibundle, mem_bytes(32'h00001003));
        csip = 32'h0000100F;
        #1;
        chk("unal_f_bundle", ibundle, mem_bytes(32'h0000100F));

        // Retry: request waits out the delay, then re-issues with a fresh tid.
        push(32'h00001020, 4'd5);
        csip = 32'h00001020;
        wait_req(t, a);
        respond(t, a, 1'b1, 3'd2);
        push(32'h00001020, 4'd6);
        push(32'h00001030, 4'd7);
        n = 0;
        while (req.cyc !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (n < RTY || n > RTY + 2) begin
            errors++;
            $display("FAIL rty_gap: got %0d cycles expected %0d..%0d", n, RTY, RTY + 2);
        end
        fill();
        fill();
        chk("rty_ihit", 128'(ihit), 128'd1);
        chk("rty_bundle", ibundle, mem_bytes(32'h00001020));

        // Conflict eviction: same index, different tag.
        csip = 32'h00001000;
        #1;
        chk("pre_evict_ihit", 128'(ihit), 128'd1);
        push(32'h00001000 + NL * 32, 4'd8);
        push(32'h00001010 + NL * 32, 4'd9);
        csip = 32'h00001000 + NL * 32;
        #1;
        chk("evict_miss", 128'(ihit), 128'd0);
        fill();
        fill();
        chk("evict_ihit", 128'(ihit), 128'd1);
        chk("evict_bundle", ibundle, mem_bytes(32'h00001000 + NL * 32));
        push(32'h00001000, 4'd10);
        push(32'h00001010, 4'd11);
        csip = 32'h00001000;
        #1;
        chk("evicted_miss", 128'(ihit), 128'd0);
        fill();
        fill();
        chk("refill_bundle", ibundle, mem_bytes(32'h00001000));

        // Invalidate during WAIT: ack discarded, line re-requested.
        push(32'h00003000, 4'd12);
        csip = 32'h00003000;
        wait_req(t, a);
        inv = 1'b1;
        step();
        inv = 1'b0;
        push(32'h00003000, 4'd13);
        push(32'h00003010, 4'd14);
        respond(t, a, 1'b0, 3'd2);
        chk("inv_discard_ihit", 128'(ihit), 128'd0);
        fill();
        fill();
        chk("inv_refill_ihit", 128'(ihit), 128'd1);
        chk("inv_refill_bundle", ibundle, mem_bytes(32'h00003000));

        // Wrong tranid and wrong channel are ignored; tid wraps 15 -> 1.
        push(32'h00004000, 4'd15);
        csip = 32'h00004000;
        wait_req(t, a);
        respond(4'd3, a, 1'b0, 3'd2);
        repeat (3) step();
        chk("bad_tid_ihit", 128'(ihit), 128'd0);
        respond(t, a, 1'b0, 3'd5);
        repeat (3) step();
        chk("bad_chan_ihit", 128'(ihit), 128'd0);
        push(32'h00004010, 4'd1);
        respond(t, a, 1'b0, 3'd2);
        fill();
        chk("wrap_ihit", 128'(ihit), 128'd1);
        chk("wrap_bundle", ibundle, mem_bytes(32'h00004000));

        repeat (5) step();
        checks++;
        if (exq.size() != 0) begin
            errors++;
            $display("FAIL leftover_reqs: got %0d pending expected 0", exq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
